// File: rtl/parity_pkg.sv
// parity_pkg: shared state encoding and parity helper used by the
// parity generator and the serial transmitter.
package parity_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_START  = S_START,
      ST_DATA   = S_DATA,
      ST_PARITY = S_PARITY,
      ST_STOP   = S_STOP
   } tx_state_e;

   // Widest word the helper handles; narrower words are zero-extended,
   // which leaves the XOR reduction unchanged.
   localparam int PAR_MAX_W = 64;

   function automatic logic calc_parity(
      input logic [PAR_MAX_W-1:0] data,
      input logic                 odd
   );
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/parity_tx_bit_timer.sv
// parity_tx_bit_timer: bit-period timer for the serial transmitter.
// Ports: clk, rst (sync, active-high), en (frame active), tick (last cycle of a bit period).
module parity_tx_bit_timer
   import parity_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   assign tick = en & (cnt_q == LAST);

   // Held at zero while disabled so each frame starts a fresh period.
   always_comb begin
      cnt_d = cnt_q;
      if (!en || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: frames one word as start, data LSB-first, parity, stop.
// Ports: clk, rst (sync, active-high), data_in/in_valid/in_ready handshake,
//        tx_out (idles high), busy (frame in progress), frame_done (last stop cycle).
module parity_serial_tx
   import parity_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              tx_q, tx_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              tick;
   logic              accept;

   assign accept     = in_valid & ready_q;
   assign in_ready   = ready_q;
   assign tx_out     = tx_q;
   assign busy       = busy_q;
   // Decoded from the state and timer flops only.
   assign frame_done = (state_q == ST_STOP) & tick;

   parity_tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .en  (state_q != ST_IDLE),
      .tick(tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      par_d     = par_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_START;
               shift_d   = data_in;
               par_d     = calc_parity(PAR_MAX_W'(data_in), PARITY_ODD);
               bit_cnt_d = '0;
            end
         end
         ST_START: begin
            if (tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = ST_PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (tick) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are precomputed from next-state values so the
   // registered line changes on the same edge as the state.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         par_q     <= 1'b0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_parity_serial_tx.sv
// tb_parity_serial_tx: scoreboard bench for parity_serial_tx with three
// configurations (even/4, odd/4, even/1 clocks per bit).
`timescale 1ns/1ps
module tb_parity_serial_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   bit blk_done [3];

   typedef struct {
      logic [7:0] w;
      int         acc;
   } exp_t;

   function automatic void chk(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d cyc%0d: got %h expected %h",
                  name, inst, cyc, act, exp);
      end
   endfunction

   // Line bit k of a frame: 0 start, 1..8 data LSB first, 9 parity, 10 stop.
   function automatic logic exp_line(input logic [7:0] w, input int k, input bit odd);
      int ones;
      ones = $countones(w);
      if (k == 0) return 1'b0;
      if (k <= 8) return w[k-1];
      if (k == 9) return ((ones + int'(odd)) % 2) == 1;
      return 1'b1;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int CPB  = (g == 2) ? 1 : 4;
      localparam bit ODD  = (g == 1);
      localparam int FLEN = 11 * CPB;

      logic       rst;
      logic       in_valid;
      logic       in_ready;
      logic       tx_out;
      logic       busy;
      logic       frame_done;
      logic [7:0] data_in;

      exp_t q[$];
      bit   rs = 1'b0;
      bit   in_frame = 1'b0;
      bit   just_ended = 1'b0;

      parity_serial_tx #(
         .DATA_W(8),
         .CLKS_PER_BIT(CPB),
         .PARITY_ODD(ODD)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .data_in   (data_in),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .tx_out    (tx_out),
         .busy      (busy),
         .frame_done(frame_done)
      );

      always @(posedge clk) rs <= rst;

      // Monitor: pops one expected word per frame and checks every cycle.
      initial begin : mon
         exp_t       e;
         int         p;
         logic [3:0] v;
         p = 0;
         forever begin
            @(negedge clk);
            v = {tx_out, frame_done, busy, in_ready};
            if (rs) begin
               in_frame   = 1'b0;
               just_ended = 1'b0;
               chk("reset_idle", g, 32'(v), 32'(4'b1001));
            end else begin
               if (!in_frame && !just_ended && busy === 1'b1) begin
                  chk("frame_queued", g, 32'(q.size() != 0), 1);
                  if (q.size() != 0) begin
                     e = q.pop_front();
                     chk("start_latency", g, cyc, e.acc + 1);
                     in_frame = 1'b1;
                     p = 0;
                  end
               end
               if (in_frame) begin
                  chk("frame_bit", g, 32'(v),
                      32'({exp_line(e.w, p / CPB, ODD), (p == FLEN - 1), 2'b10}));
                  p++;
                  if (p == FLEN) begin
                     in_frame   = 1'b0;
                     just_ended = 1'b1;
                  end
               end else begin
                  chk("idle", g, 32'(v), 32'(4'b1001));
                  just_ended = 1'b0;
               end
            end
         end
      end

      task automatic send(input logic [7:0] w, input bit hold);
         int t;
         t = 0;
         @(negedge clk);
         while (in_ready !== 1'b1 && t < 300) begin
            data_in  = 8'($urandom);
            in_valid = hold ? 1'b1 : 1'($urandom);
            t++;
            @(negedge clk);
         end
         chk("ready_wait", g, 32'(t >= 300), 0);
         if (in_ready === 1'b1) begin
            in_valid = 1'b1;
            data_in  = w;
            q.push_back('{w, cyc});
            @(posedge clk);
            #1;
            in_valid = hold;
            data_in  = 8'($urandom);
         end
      endtask

      task automatic idle_gap(input int n);
         int t;
         t = 0;
         @(negedge clk);
         while (in_ready !== 1'b1 && t < 300) begin
            data_in  = 8'($urandom);
            in_valid = 1'($urandom);
            t++;
            @(negedge clk);
         end
         in_valid = 1'b0;
         chk("gap_wait", g, 32'(t >= 300), 0);
         repeat (n) @(negedge clk);
      endtask

      initial begin : stim
         int  n_rand;
         bit  hold;
         bit  prev_hold;
         int  t;
         rst      = 1'b1;
         in_valid = 1'b0;
         data_in  = 8'h00;
         repeat (3) @(posedge clk);
         #1 rst = 1'b0;
         case (g)
            0: begin
               send(8'h01, 1'b0);
               send(8'hAA, 1'b0);
               send(8'hFF, 1'b0);
               send(8'h00, 1'b0);
               idle_gap(2);
               send(8'h03, 1'b1);
               send(8'hF0, 1'b0);
               idle_gap(1);
               send(8'h55, 1'b0);
               repeat (18) @(posedge clk);
               #1 rst = 1'b1;
               @(posedge clk);
               #1 rst = 1'b0;
               send(8'h0F, 1'b0);
               n_rand = 20;
            end
            1: begin
               send(8'hAA, 1'b0);
               send(8'hFF, 1'b0);
               send(8'h00, 1'b0);
               n_rand = 10;
            end
            default: begin
               send(8'h80, 1'b0);
               n_rand = 10;
            end
         endcase
         prev_hold = 1'b0;
         for (int i = 0; i < n_rand; i++) begin
            hold = 1'($urandom);
            if (i == n_rand - 1) hold = 1'b0;
            if (!prev_hold && ($urandom % 2 == 0))
               idle_gap($urandom_range(0, 3));
            send(8'($urandom), hold);
            prev_hold = hold;
         end
         t = 0;
         while ((q.size() != 0 || in_frame) && t < 300) begin
            @(negedge clk);
            t++;
         end
         chk("drain", g, 32'(t >= 300), 0);
         repeat (3) @(negedge clk);
         blk_done[g] = 1'b1;
      end
   end

   initial begin : top_ctl
      int t;
      t = 0;
      while (!(blk_done[0] && blk_done[1] && blk_done[2]) && t < 20000) begin
         @(posedge clk);
         t++;
      end
      chk("all_done", 0, 32'(t >= 20000), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
